// File: rtl/decode_stage.sv
// Registered RISC-V decode stage: classifies the opcode, selects the immediate
// format and holds the result in one valid/ready pipeline slot with flush.
module decode_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [2:0]       imm_sel,
  output logic             imm_used,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] SEL_SEX12 = 3'b000;
  localparam logic [2:0] SEL_UEX12 = 3'b001;
  localparam logic [2:0] SEL_B_IMM = 3'b010;
  localparam logic [2:0] SEL_JALEX = 3'b011;
  localparam logic [2:0] SEL_U_IMM = 3'b100;
  localparam logic [2:0] SEL_S_IMM = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  logic [2:0] dec_sel;
  logic       dec_used;
  logic       dec_illegal;
  logic       load;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dec_sel     = SEL_SEX12;
    dec_used    = 1'b1;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      OP_LOAD, OP_JALR: dec_sel = SEL_SEX12;
      OP_IMM:
        if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) dec_sel = SEL_UEX12;
      OP_STORE:         dec_sel = SEL_S_IMM;
      OP_BRANCH:        dec_sel = SEL_B_IMM;
      OP_JAL:           dec_sel = SEL_JALEX;
      OP_LUI, OP_AUIPC: dec_sel = SEL_U_IMM;
      OP_REG:           dec_used = 1'b0;
      default: begin
        dec_used    = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Flush drains the offered instruction, so the stage is always ready then.
  assign in_ready  = flush | (state == EMPTY) | out_ready;
  assign load      = in_valid & in_ready & ~flush;
  assign out_valid = (state == FULL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= EMPTY;
      out_instr     <= '0;
      out_pc        <= '0;
      imm_sel       <= '0;
      imm_used      <= 1'b0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (load) begin
      state     <= FULL;
      out_instr <= in_instr;
      out_pc    <= in_pc;
      imm_sel   <= dec_sel;
      imm_used  <= dec_used;
      illegal   <= dec_illegal;
      if (dec_illegal && illegal_count != '1)
        illegal_count <= illegal_count + CNT_ONE;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule
